// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
//   Registered decode stage for the Jahangir MIPS32 pipeline. It sits between
//   the IF/ID register and EX. It decodes the logic-immediate instructions
//   (ORI/ANDI/XORI/LUI), the R-type logic instructions (AND/OR/XOR/NOR) and NOP.
//   It reads operands from the regfile, detects RAW hazards against results
//   still pending in EX/MEM, and registers the decoded bundle.
//
// Build option
//   ID_FWD_EN : when defined, operands matching a pending EX/MEM write are
//               bypassed. EX has priority over MEM, and MEM over the regfile.
//               The stage then never stalls. When undefined, any such match
//               stalls the instruction until EX/MEM no longer match.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    IF/ID side handshake; in_pc, in_inst carry the payload
//   rf_rd{1,2}_en/addr   regfile read request (combinational from in_inst)
//   rf_rd{1,2}_data      regfile read data, returned in the same cycle
//   ex_wr_*, mem_wr_*    destination writes still pending in EX and MEM
//   out_valid/out_ready  EX side handshake
//   out_pc, out_opnd1/2, out_alu_op, out_alu_sel, out_wr_en, out_wr_addr,
//   out_inst_invalid     registered decoded bundle
//   stall_cnt            saturating count of cycles lost to hazard stalls
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
//   high. The output register advances whenever it is empty or EX takes it
//   (adv = !out_valid || out_ready). An instruction is accepted when adv is
//   high and it has no unresolved hazard. Every other advancing cycle loads a
//   bubble. While adv is low, every output field holds.
// -----------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_pc,
  input  logic [31:0]         in_inst,
  output logic                rf_rd1_en,
  output logic                rf_rd2_en,
  output logic [REG_AW-1:0]   rf_rd1_addr,
  output logic [REG_AW-1:0]   rf_rd2_addr,
  input  logic [DATA_W-1:0]   rf_rd1_data,
  input  logic [DATA_W-1:0]   rf_rd2_data,
  input  logic                ex_wr_en,
  input  logic [REG_AW-1:0]   ex_wr_addr,
  input  logic [DATA_W-1:0]   ex_wr_data,
  input  logic                mem_wr_en,
  input  logic [REG_AW-1:0]   mem_wr_addr,
  input  logic [DATA_W-1:0]   mem_wr_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_pc,
  output logic [DATA_W-1:0]   out_opnd1,
  output logic [DATA_W-1:0]   out_opnd2,
  output logic [ALUOP_W-1:0]  out_alu_op,
  output logic [ALUSEL_W-1:0] out_alu_sel,
  output logic                out_wr_en,
  output logic [REG_AW-1:0]   out_wr_addr,
  output logic                out_inst_invalid,
  output logic [15:0]         stall_cnt
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs_f, rt_f, rd_f, shamt_f;
  logic [5:0]  funct_f;
  logic [15:0] imm16;

  assign opcode  = in_inst[31:26];
  assign rs_f    = in_inst[25:21];
  assign rt_f    = in_inst[20:16];
  assign rd_f    = in_inst[15:11];
  assign shamt_f = in_inst[10:6];
  assign funct_f = in_inst[5:0];
  assign imm16   = in_inst[15:0];

  // Decode
  logic                dec_rd1_en, dec_rd2_en, dec_wr_en, dec_invalid;
  logic [DATA_W-1:0]   dec_imm;
  logic [ALUOP_W-1:0]  dec_alu_op;
  logic [ALUSEL_W-1:0] dec_alu_sel;
  logic [REG_AW-1:0]   dec_wr_addr;

  always_comb begin
    dec_rd1_en  = 1'b0;
    dec_rd2_en  = 1'b0;
    dec_wr_en   = 1'b0;
    dec_invalid = 1'b0;
    dec_imm     = '0;
    dec_alu_op  = '0;
    dec_alu_sel = '0;
    dec_wr_addr = '0;
    // An all-zero word is a NOP; it must be tested before the SPECIAL decode.
    if (in_inst != 32'h0) begin
      case (opcode)
        OP_ORI, OP_ANDI, OP_XORI: begin
          dec_rd1_en  = 1'b1;
          dec_imm     = DATA_W'(imm16);
          dec_alu_sel = ALUSEL_W'(3'b001);
          dec_wr_en   = 1'b1;
          dec_wr_addr = REG_AW'(rt_f);
          if (opcode == OP_ANDI)      dec_alu_op = ALUOP_W'(8'h24);
          else if (opcode == OP_ORI)  dec_alu_op = ALUOP_W'(8'h25);
          else                        dec_alu_op = ALUOP_W'(8'h26);
        end
        OP_LUI: begin
          dec_imm     = DATA_W'({imm16, 16'h0000});
          dec_alu_op  = ALUOP_W'(8'h25);
          dec_alu_sel = ALUSEL_W'(3'b001);
          dec_wr_en   = 1'b1;
          dec_wr_addr = REG_AW'(rt_f);
        end
        OP_SPECIAL: begin
          // funct 0x24..0x27 share the prefix 4'b1001
          if (shamt_f == 5'd0 && funct_f[5:2] == 4'b1001) begin
            dec_rd1_en  = 1'b1;
            dec_rd2_en  = 1'b1;
            dec_alu_op  = ALUOP_W'({2'b00, funct_f});
            dec_alu_sel = ALUSEL_W'(3'b001);
            dec_wr_en   = 1'b1;
            dec_wr_addr = REG_AW'(rd_f);
          end else begin
            dec_invalid = 1'b1;
          end
        end
        default: dec_invalid = 1'b1;
      endcase
    end
  end

  // Reads are only requested for a valid instruction, so an idle IF/ID
  // cannot raise a hazard or stall.
  assign rf_rd1_en   = in_valid && dec_rd1_en;
  assign rf_rd2_en   = in_valid && dec_rd2_en;
  assign rf_rd1_addr = REG_AW'(rs_f);
  assign rf_rd2_addr = REG_AW'(rt_f);

  // Hazard matching; register 0 never matches.
  logic rd1_zero, rd2_zero;
  logic ex_hit1, mem_hit1, ex_hit2, mem_hit2;
  logic stall;

  assign rd1_zero = (rf_rd1_addr == '0);
  assign rd2_zero = (rf_rd2_addr == '0);
  assign ex_hit1  = ex_wr_en  && (ex_wr_addr  == rf_rd1_addr);
  assign mem_hit1 = mem_wr_en && (mem_wr_addr == rf_rd1_addr);
  assign ex_hit2  = ex_wr_en  && (ex_wr_addr  == rf_rd2_addr);
  assign mem_hit2 = mem_wr_en && (mem_wr_addr == rf_rd2_addr);

  logic [DATA_W-1:0] opnd1, opnd2;

`ifdef ID_FWD_EN
  assign stall = 1'b0;

  always_comb begin
    opnd1 = '0;
    if (rf_rd1_en && !rd1_zero) begin
      if (ex_hit1)       opnd1 = ex_wr_data;
      else if (mem_hit1) opnd1 = mem_wr_data;
      else               opnd1 = rf_rd1_data;
    end
  end

  always_comb begin
    opnd2 = dec_imm;
    if (rf_rd2_en) begin
      if (rd2_zero)      opnd2 = '0;
      else if (ex_hit2)  opnd2 = ex_wr_data;
      else if (mem_hit2) opnd2 = mem_wr_data;
      else               opnd2 = rf_rd2_data;
    end
  end
`else
  assign stall = (rf_rd1_en && !rd1_zero && (ex_hit1 || mem_hit1)) ||
                 (rf_rd2_en && !rd2_zero && (ex_hit2 || mem_hit2));

  // Pending write data is only needed for bypassing.
  logic unused_bypass_data;
  assign unused_bypass_data = ^{ex_wr_data, mem_wr_data};

  always_comb begin
    opnd1 = '0;
    if (rf_rd1_en && !rd1_zero) opnd1 = rf_rd1_data;
  end

  always_comb begin
    opnd2 = dec_imm;
    if (rf_rd2_en) opnd2 = rd2_zero ? '0 : rf_rd2_data;
  end
`endif

  // Output register
  logic                valid_q, valid_d;
  logic [31:0]         pc_q, pc_d;
  logic [DATA_W-1:0]   opnd1_q, opnd1_d, opnd2_q, opnd2_d;
  logic [ALUOP_W-1:0]  alu_op_q, alu_op_d;
  logic [ALUSEL_W-1:0] alu_sel_q, alu_sel_d;
  logic                wr_en_q, wr_en_d;
  logic [REG_AW-1:0]   wr_addr_q, wr_addr_d;
  logic                invalid_q, invalid_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                adv;

  assign adv      = !valid_q || out_ready;
  assign in_ready = rst_n && adv && !stall;

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    opnd1_d   = opnd1_q;
    opnd2_d   = opnd2_q;
    alu_op_d  = alu_op_q;
    alu_sel_d = alu_sel_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    invalid_d = invalid_q;
    cnt_d     = cnt_q;
    if (adv) begin
      if (in_valid && !stall) begin
        valid_d   = 1'b1;
        pc_d      = in_pc;
        opnd1_d   = opnd1;
        opnd2_d   = opnd2;
        alu_op_d  = dec_alu_op;
        alu_sel_d = dec_alu_sel;
        wr_en_d   = dec_wr_en;
        wr_addr_d = dec_wr_addr;
        invalid_d = dec_invalid;
      end else begin
        // Bubble: every field is cleared so EX sees a clean no-op.
        valid_d   = 1'b0;
        pc_d      = '0;
        opnd1_d   = '0;
        opnd2_d   = '0;
        alu_op_d  = '0;
        alu_sel_d = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        invalid_d = 1'b0;
      end
    end
    if (in_valid && adv && stall && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      opnd1_q   <= '0;
      opnd2_q   <= '0;
      alu_op_q  <= '0;
      alu_sel_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      invalid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      opnd1_q   <= opnd1_d;
      opnd2_q   <= opnd2_d;
      alu_op_q  <= alu_op_d;
      alu_sel_q <= alu_sel_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      invalid_q <= invalid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid        = valid_q;
  assign out_pc           = pc_q;
  assign out_opnd1        = opnd1_q;
  assign out_opnd2        = opnd2_q;
  assign out_alu_op       = alu_op_q;
  assign out_alu_sel      = alu_sel_q;
  assign out_wr_en        = wr_en_q;
  assign out_wr_addr      = wr_addr_q;
  assign out_inst_invalid = invalid_q;
  assign stall_cnt        = cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;

`ifdef ID_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc;
  logic        rf_rd1_en, rf_rd2_en;
  logic [4:0]  rf_rd1_addr, rf_rd2_addr;
  logic [31:0] rf_rd1_data, rf_rd2_data;
  logic        ex_wr_en, mem_wr_en;
  logic [4:0]  ex_wr_addr, mem_wr_addr;
  logic [31:0] ex_wr_data, mem_wr_data;
  logic [31:0] out_opnd1, out_opnd2;
  logic [7:0]  out_alu_op;
  logic [2:0]  out_alu_sel;
  logic        out_wr_en, out_inst_invalid;
  logic [4:0]  out_wr_addr;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rf_rd1_en(rf_rd1_en), .rf_rd2_en(rf_rd2_en),
    .rf_rd1_addr(rf_rd1_addr), .rf_rd2_addr(rf_rd2_addr),
    .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opnd1(out_opnd1), .out_opnd2(out_opnd2),
    .out_alu_op(out_alu_op), .out_alu_sel(out_alu_sel),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
    .out_inst_invalid(out_inst_invalid), .stall_cnt(stall_cnt)
  );

  // ---------------- types ----------------
  typedef struct packed {
    logic        rst_n;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        ex_en;
    logic [4:0]  ex_a;
    logic [31:0] ex_d;
    logic        mem_en;
    logic [4:0]  mem_a;
    logic [31:0] mem_d;
    logic        ordy;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic        we;
    logic [4:0]  wa;
    logic        inv;
  } bundle_t;

  typedef struct packed {
    logic    e1;
    logic    e2;
    logic    haz;
    bundle_t b;
  } dec_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        e1;
    logic        e2;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic        we;
    logic [4:0]  wa;
    logic        inv;
  } vec_t;

  localparam int BW = $bits(bundle_t);

  // ---------------- scoreboard / model state ----------------
  int             checks = 0;
  int             errors = 0;
  logic [BW-1:0]  exp_q[$];
  logic           m_valid = 1'b0;
  logic [15:0]    m_cnt = 16'h0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Value a read port delivers for register a; haz reports a pending write to a.
  function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rf,
                                              input stim_t s, output logic haz);
    logic ex_m, mem_m;
    ex_m  = s.ex_en  && (s.ex_a  == a);
    mem_m = s.mem_en && (s.mem_a == a);
    haz   = (a != 5'd0) && (ex_m || mem_m);
    if (a == 5'd0) return 32'h0;
    if (FWD && ex_m)  return s.ex_d;
    if (FWD && mem_m) return s.mem_d;
    return rf;
  endfunction

  function automatic dec_t ref_decode(input stim_t s);
    dec_t        d;
    logic        h1, h2;
    logic [31:0] v1, v2;
    logic [5:0]  opc, fn;
    opc = s.inst[31:26];
    fn  = s.inst[5:0];
    d = '0;
    d.b.pc = s.pc;
    v1 = ref_operand(s.inst[25:21], s.rd1, s, h1);
    v2 = ref_operand(s.inst[20:16], s.rd2, s, h2);
    if (s.inst == 32'h0) begin
      // NOP: valid bundle, nothing to do
    end else if (opc == 6'h0C || opc == 6'h0D || opc == 6'h0E) begin
      d.e1 = 1'b1; d.haz = h1;
      d.b.o1 = v1; d.b.o2 = {16'h0, s.inst[15:0]};
      d.b.op = (opc == 6'h0C) ? 8'h24 : (opc == 6'h0D) ? 8'h25 : 8'h26;
      d.b.sel = 3'b001; d.b.we = 1'b1; d.b.wa = s.inst[20:16];
    end else if (opc == 6'h0F) begin
      d.b.o2 = {s.inst[15:0], 16'h0}; d.b.op = 8'h25;
      d.b.sel = 3'b001; d.b.we = 1'b1; d.b.wa = s.inst[20:16];
    end else if (opc == 6'h00 && s.inst[10:6] == 5'd0 && fn >= 6'h24 && fn <= 6'h27) begin
      d.e1 = 1'b1; d.e2 = 1'b1; d.haz = h1 || h2;
      d.b.o1 = v1; d.b.o2 = v2; d.b.op = {2'b00, fn};
      d.b.sel = 3'b001; d.b.we = 1'b1; d.b.wa = s.inst[15:11];
    end else begin
      d.b.inv = 1'b1;
    end
    return d;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input stim_t s);
    rst_n = s.rst_n; in_valid = s.valid; in_pc = s.pc; in_inst = s.inst;
    rf_rd1_data = s.rd1; rf_rd2_data = s.rd2;
    ex_wr_en = s.ex_en; ex_wr_addr = s.ex_a; ex_wr_data = s.ex_d;
    mem_wr_en = s.mem_en; mem_wr_addr = s.mem_a; mem_wr_data = s.mem_d;
    out_ready = s.ordy;
  endtask

  function automatic stim_t base_stim(input logic [31:0] inst);
    stim_t s;
    s = '0;
    s.rst_n = 1'b1; s.valid = 1'b1; s.ordy = 1'b1; s.inst = inst;
    s.pc = $urandom;
    return s;
  endfunction

  // One clock: drive, check combinational outputs and consumed bundles,
  // advance the model across the edge, check registered state.
  task automatic step(input stim_t s);
    dec_t    d;
    bundle_t act;
    logic    adv, stall, acc;
    logic [BW-1:0] e;
    drive(s);
    #1;
    d     = ref_decode(s);
    adv   = !m_valid || s.ordy;
    stall = s.valid && d.haz && !FWD;
    acc   = s.rst_n && adv && s.valid && !stall;
    chk("in_ready", in_ready, s.rst_n && adv && !stall);
    if (s.valid) begin
      chk("rd1_en", rf_rd1_en, d.e1);
      chk("rd2_en", rf_rd2_en, d.e2);
    end
    if (s.rst_n && s.ordy && out_valid) begin
      act = '{pc: out_pc, o1: out_opnd1, o2: out_opnd2, op: out_alu_op, sel: out_alu_sel,
              we: out_wr_en, wa: out_wr_addr, inv: out_inst_invalid};
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_bundle", act, 128'h0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_bundle", act, e);
      end
    end
    if (acc) exp_q.push_back(d.b);
    @(posedge clk);
    if (!s.rst_n) begin
      m_valid = 1'b0;
      m_cnt   = 16'h0;
      exp_q.delete();
    end else begin
      if (s.valid && adv && stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (adv) m_valid = acc;
    end
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (!out_valid) chk("bubble_wr_en", out_wr_en, 1'b0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    case ($urandom_range(0, 9))
      0: return {6'h0D, rs, rt, imm};
      1: return {6'h0C, rs, rt, imm};
      2: return {6'h0E, rs, rt, imm};
      3: return {6'h0F, 5'd0, rt, imm};
      4, 5: return {6'h00, rs, rt, rd, 5'd0, 6'h24 + 6'($urandom_range(0, 3))};
      6: return 32'h0;
      7: return $urandom;
      8: return {6'h00, rs, rt, rd, 5'($urandom_range(1, 31)), 6'h25};
      default: return {6'h00, rs, rt, rd, 5'd0, 6'($urandom)};
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = base_stim(rand_inst());
    s.rst_n  = ($urandom_range(0, 99) != 0);
    s.valid  = ($urandom_range(0, 3) != 0);
    s.ordy   = ($urandom_range(0, 3) != 0);
    s.rd1    = $urandom;
    s.rd2    = $urandom;
    s.ex_en  = ($urandom_range(0, 2) == 0);
    s.ex_a   = 5'($urandom_range(0, 3));
    s.ex_d   = $urandom;
    s.mem_en = ($urandom_range(0, 2) == 0);
    s.mem_a  = 5'($urandom_range(0, 3));
    s.mem_d  = $urandom;
    return s;
  endfunction

  // ---------------- test ----------------
  vec_t  vecs[13];
  stim_t s, sh, sa;
  logic [15:0] cnt_after_haz;

  initial begin
    vecs[0]  = '{32'h3423_00FF, 32'h1234_0000, 32'h0, 1'b1, 1'b0, 32'h1234_0000, 32'h0000_00FF, 8'h25, 3'b001, 1'b1, 5'd3,  1'b0};
    vecs[1]  = '{32'h0040_2827, 32'hAAAA_AAAA, 32'h1111_1111, 1'b1, 1'b1, 32'hAAAA_AAAA, 32'h0, 8'h27, 3'b001, 1'b1, 5'd5, 1'b0};
    vecs[2]  = '{32'h3C07_BEEF, 32'h9999_9999, 32'h0, 1'b0, 1'b0, 32'h0, 32'hBEEF_0000, 8'h25, 3'b001, 1'b1, 5'd7,  1'b0};
    vecs[3]  = '{32'h3089_8001, 32'hF0F0_F0F0, 32'h0, 1'b1, 1'b0, 32'hF0F0_F0F0, 32'h0000_8001, 8'h24, 3'b001, 1'b1, 5'd9,  1'b0};
    vecs[4]  = '{32'h3BFF_FFFF, 32'h0000_1234, 32'h0, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_FFFF, 8'h26, 3'b001, 1'b1, 5'd31, 1'b0};
    vecs[5]  = '{32'h00C7_4024, 32'h0123_4567, 32'h89AB_CDEF, 1'b1, 1'b1, 32'h0123_4567, 32'h89AB_CDEF, 8'h24, 3'b001, 1'b1, 5'd8, 1'b0};
    vecs[6]  = '{32'h016C_5025, 32'hDEAD_0000, 32'h0000_BEEF, 1'b1, 1'b1, 32'hDEAD_0000, 32'h0000_BEEF, 8'h25, 3'b001, 1'b1, 5'd10, 1'b0};
    vecs[7]  = '{32'h0002_0826, 32'h7777_7777, 32'h5A5A_5A5A, 1'b1, 1'b1, 32'h0, 32'h5A5A_5A5A, 8'h26, 3'b001, 1'b1, 5'd1, 1'b0};
    vecs[8]  = '{32'h0, 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'b000, 1'b0, 5'd0, 1'b0};
    vecs[9]  = '{32'hFC21_1234, 32'h1, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'b000, 1'b0, 5'd0, 1'b1};
    vecs[10] = '{32'h0022_1820, 32'h1, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'b000, 1'b0, 5'd0, 1'b1};
    vecs[11] = '{32'h0022_1865, 32'h1, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'b000, 1'b0, 5'd0, 1'b1};
    vecs[12] = '{32'h3405_0042, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0000_0042, 8'h25, 3'b001, 1'b1, 5'd5, 1'b0};
    cnt_after_haz = FWD ? 16'd0 : 16'd4;

    // Reset
    s = base_stim(32'h0);
    s.rst_n = 1'b0; s.valid = 1'b0;
    step(s);
    step(s);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_stall_cnt", stall_cnt, 16'h0);
    chk("reset_bundle", {out_pc, out_opnd1, out_opnd2, out_alu_op, out_alu_sel,
                         out_wr_en, out_wr_addr, out_inst_invalid}, 128'h0);

    // Decode table, back to back
    for (int i = 0; i < 13; i++) begin
      s = base_stim(vecs[i].inst);
      s.rd1 = vecs[i].rd1; s.rd2 = vecs[i].rd2;
      drive(s);
      #1;
      chk($sformatf("v%0d_rd1_en", i), rf_rd1_en, vecs[i].e1);
      chk($sformatf("v%0d_rd2_en", i), rf_rd2_en, vecs[i].e2);
      step(s);
      chk($sformatf("v%0d_valid", i),   out_valid, 1'b1);
      chk($sformatf("v%0d_pc", i),      out_pc, s.pc);
      chk($sformatf("v%0d_opnd1", i),   out_opnd1, vecs[i].o1);
      chk($sformatf("v%0d_opnd2", i),   out_opnd2, vecs[i].o2);
      chk($sformatf("v%0d_alu_op", i),  out_alu_op, vecs[i].op);
      chk($sformatf("v%0d_alu_sel", i), out_alu_sel, vecs[i].sel);
      chk($sformatf("v%0d_wr_en", i),   out_wr_en, vecs[i].we);
      chk($sformatf("v%0d_wr_addr", i), out_wr_addr, vecs[i].wa);
      chk($sformatf("v%0d_invalid", i), out_inst_invalid, vecs[i].inv);
    end

    // RAW hazard: ORI $4,$3,1 with $3 pending in both EX and MEM
    sh = base_stim(32'h3464_0001);
    sh.rd1 = 32'h77;
    sh.ex_en = 1'b1;  sh.ex_a = 5'd3;  sh.ex_d = 32'h55;
    sh.mem_en = 1'b1; sh.mem_a = 5'd3; sh.mem_d = 32'h66;
    for (int i = 0; i < 3; i++) begin
      step(sh);
      chk("haz_out_valid", out_valid, FWD);
      if (FWD) chk("haz_fwd_ex", out_opnd1, 32'h55);
      chk("haz_cnt", stall_cnt, FWD ? 16'd0 : 16'(i + 1));
    end
    sh.ex_en = 1'b0;
    step(sh);
    chk("haz_mem_out_valid", out_valid, FWD);
    if (FWD) chk("haz_fwd_mem", out_opnd1, 32'h66);
    chk("haz_mem_cnt", stall_cnt, cnt_after_haz);
    sh.mem_en = 1'b0;
    step(sh);
    chk("haz_clear_valid", out_valid, 1'b1);
    chk("haz_clear_opnd1", out_opnd1, 32'h77);
    chk("haz_clear_cnt", stall_cnt, cnt_after_haz);
    // A pending write to $0 is never a hazard nor a bypass source
    s = base_stim(32'h3405_0042);
    s.rd1 = 32'h1; s.ex_en = 1'b1; s.ex_a = 5'd0; s.ex_d = 32'h99;
    step(s);
    chk("r0_valid", out_valid, 1'b1);
    chk("r0_opnd1", out_opnd1, 32'h0);

    // Back-pressure: bundle holds for 3 cycles, a hazard meanwhile is not counted
    sa = base_stim(32'h3423_00FF);
    sa.rd1 = 32'h1234_0000;
    step(sa);
    sh.ex_en = 1'b1; sh.ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(sh);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_pc", out_pc, sa.pc);
      chk("hold_opnd1", out_opnd1, 32'h1234_0000);
      chk("hold_opnd2", out_opnd2, 32'h0000_00FF);
      chk("hold_wr_addr", out_wr_addr, 5'd3);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_cnt", stall_cnt, cnt_after_haz);
    end
    s = base_stim(32'h0);
    s.valid = 1'b0;
    step(s);
    chk("release_bubble", out_valid, 1'b0);

    // Invalid opcode, then reset on the next cycle
    s = base_stim(32'hFC00_0000);
    step(s);
    chk("inv_flag", out_inst_invalid, 1'b1);
    chk("inv_wr_en", out_wr_en, 1'b0);
    s = base_stim(32'h3423_00FF);
    s.rst_n = 1'b0;
    step(s);
    chk("rst_all_zero", {out_valid, out_pc, out_opnd1, out_opnd2, out_alu_op, out_alu_sel,
                         out_wr_en, out_wr_addr, out_inst_invalid, stall_cnt}, 128'h0);
    s = base_stim(32'h0);
    s.valid = 1'b0;
    step(s);
    chk("rst_no_replay", out_valid, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) step(rand_stim());
    s = base_stim(32'h0);
    s.valid = 1'b0;
    step(s);
    step(s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
